lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised LIFO stack, the successor to the CPU's fixed 8-bit × 32 operand stack, used by the multicycle datapath for push/pop/top-of-stack operand traffic. It adds configurable width and depth, occupancy count, full/empty flags, defined simultaneous push+pop behaviour, and a registered output-valid strobe. Overflow and underflow are always blocked; sticky error reporting is optional.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 32: number of entries, ≥2; need not be a power of two.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk` externally.
- `din` input WIDTH: data to push.
- `push` input 1: push `din` this cycle.
- `pop` input 1: remove the top entry and return it on `dout`.
- `tos` input 1: return the top entry on `dout` without removing it.
- `err_clr` input 1: clear sticky error flags; present only with `STACK_ERR_EN`.
- `dout` output WIDTH: registered read data; holds its last value until the next successful read.
- `dout_valid` output 1: one-cycle pulse, high in the cycle after a successful read.
- `count` output $clog2(DEPTH+1): current occupancy.
- `empty` output 1: `count == 0`, combinational from `count`.
- `full` output 1: `count == DEPTH`, combinational from `count`.
- `ovf` output 1: sticky overflow flag; present only with `STACK_ERR_EN`.
- `unf` output 1: sticky underflow flag; present only with `STACK_ERR_EN`.

## Operation
- Storage: DEPTH × WIDTH array. Entry `count-1` is the top. The array is not reset.
- Push only, not full: write `mem[count] <= din`; increment `count`.
- Push only, full: overflow. The write is ignored and `count` is unchanged.
- Pop only, not empty: `dout <= mem[count-1]`; decrement `count`; pulse `dout_valid`.
- Pop only, empty: underflow. `dout` holds, `dout_valid` stays 0, and `count` stays 0.
- tos only, not empty: `dout <= mem[count-1]`; pulse `dout_valid`; `count` is unchanged.
- tos only, empty: underflow, with the same response as pop on empty.
- Push + pop, not empty (full included): replace operation.
  - `dout <= mem[count-1]`, then `mem[count-1] <= din`.
  - `count` is unchanged; `dout_valid` pulses.
  - No overflow is flagged, even when full.
- Push + pop, empty: bypass operation.
  - `dout <= din`; `dout_valid` pulses.
  - `count` stays 0; no error is flagged.
- tos with pop: pop takes priority and tos is ignored. tos with push, without pop: the push is performed and `dout` returns the pre-push top. If the stack is empty, tos flags underflow and the push still occurs.
- Reset: `count=0`, `empty=1`, `full=0`, `dout=0`, `dout_valid=0`, `ovf=0`, `unf=0`.
  - Reset mid-operation discards all contents logically, regardless of the in-flight operation.

## Timing
- All state, including `count`, `dout`, `dout_valid`, the memory and the flags, updates on the `clk` rising edge.
- Read latency is one cycle: a request in cycle N gives `dout`/`dout_valid` in cycle N+1.
- Back-to-back operations are accepted every cycle with no stall. There is no handshake beyond the strobes, and `count`/`full`/`empty` already reflect cycle N's operation in N+1.
- A push in cycle N followed by pop or tos in N+1 returns the pushed value, since the memory is written in N.

## Configuration
- `STACK_ERR_EN` defined:
  - `ovf`/`unf` ports exist.
  - Each sets on the first overflow/underflow event and stays set until `err_clr`.
  - `err_clr` clears both flags on the next edge. If `err_clr` coincides with a new event, the set wins.
- `STACK_ERR_EN` undefined: `ovf`, `unf` and `err_clr` are absent. Blocking behaviour on overflow/underflow is identical.

## Structure
- Package `stack_pkg`:
  - Operation-decode enum: `OP_NONE`, `OP_PUSH`, `OP_POP`, `OP_TOS`, `OP_REPLACE`, `OP_BYPASS`.
  - Count-width helper function.
- Top-level `lifo_stack` contains the decode/priority logic, the count register, the output registers and the error flags.
- One sub-module, `stack_mem`: DEPTH × WIDTH register file with one synchronous write port and one asynchronous read port at address `count-1`.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset, then push 0x11, 0x22, 0x33, 0x44 -> `count`=4, `full`=1; a fifth push of 0x55 -> `count` stays 4, `ovf`=1.
- Pop ×4 from the above -> `dout` = 0x44, 0x33, 0x22, 0x11, each with `dout_valid` one cycle after the request; then `empty`=1. A further pop -> `unf`=1, `dout` holds 0x11, `dout_valid`=0.
- Push 0xA0, then tos twice -> `dout`=0xA0 twice with `count`=1. Then push+pop with `din`=0xB0 -> `dout`=0xA0, `count`=1; a following pop returns 0xB0.
- Empty stack, push+pop with `din`=0x5A -> `dout`=0x5A, `dout_valid`=1, `count`=0, no error.
- Full stack, push+pop with `din`=0x99 -> `dout`=old top, `count`=4, `ovf` unchanged; a following pop returns 0x99.
- Assert `rst` low mid-sequence with `count`=3 -> `count`=0, `dout`=0, `dout_valid`=0 and the flags clear immediately. With `STACK_ERR_EN`, `err_clr` coinciding with an overflow -> `ovf` stays 1.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - operation decode enum and sizing helpers for lifo_stack
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_TOS     = 3'd3,
        OP_REPLACE = 3'd4,
        OP_BYPASS  = 3'd5
    } stack_op_e;

    // Occupancy needs to represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entry index 0..depth-1, never narrower than one bit
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH register file, one sync write port, one async read port
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [addr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [addr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]             rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO stack; define STACK_ERR_EN for sticky ovf/unf flags with err_clr
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              din,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          tos,
`ifdef STACK_ERR_EN
    input  logic                          err_clr,
    output logic                          ovf,
    output logic                          unf,
`endif
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          full
);

    localparam int CW = count_width(DEPTH);
    localparam int AW = addr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    stack_op_e        op;
    logic [CW-1:0]    count_nxt;
    logic             rd_en;
    logic             rd_from_din;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_data;
    logic             ovf_evt;
    logic             unf_evt;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign top_addr = AW'(count - ONE_C);

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (din),
        .rd_addr (top_addr),
        .rd_data (top_data)
    );

    // Decode request lines into one operation; pop outranks tos
    always_comb begin
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_BYPASS : OP_REPLACE;
        end else if (pop) begin
            op = OP_POP;
        end else if (push) begin
            op = OP_PUSH;
        end else if (tos) begin
            op = OP_TOS;
        end
    end

    // Per-operation effects; a push may carry a tos that reads the pre-push top
    always_comb begin
        count_nxt   = count;
        rd_en       = 1'b0;
        rd_from_din = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = top_addr;
        ovf_evt     = 1'b0;
        unf_evt     = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(count);
                    count_nxt = count + ONE_C;
                end
                if (tos) begin
                    if (empty) begin
                        unf_evt = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_evt = 1'b1;
                end else begin
                    rd_en     = 1'b1;
                    count_nxt = count - ONE_C;
                end
            end
            OP_TOS: begin
                if (empty) begin
                    unf_evt = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
            end
            OP_REPLACE: begin
                rd_en  = 1'b1;
                mem_we = 1'b1;
            end
            OP_BYPASS: begin
                rd_en       = 1'b1;
                rd_from_din = 1'b1;
            end
            default: begin
                count_nxt = count;
            end
        endcase
    end

    // Occupancy and registered read data; dout holds until the next successful read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            count      <= count_nxt;
            dout_valid <= rd_en;
            if (rd_en) begin
                dout <= rd_from_din ? din : top_data;
            end
        end
    end

`ifdef STACK_ERR_EN
    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (unf_evt) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end
`else
    logic unused_evt;
    assign unused_evt = ovf_evt | unf_evt;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack (WIDTH=8, DEPTH=4), queue model plus directed literals
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int vectors = 0;
    int miscompares = 0;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .push       (push),
        .pop        (pop),
        .tos        (tos),
`ifdef STACK_ERR_EN
        .err_clr    (err_clr),
        .ovf        (ovf),
        .unf        (unf),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

`ifndef STACK_ERR_EN
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: the stack as a queue whose back is the top
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_dv = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit oe;
            bit ue;
            oe   = 1'b0;
            ue   = 1'b0;
            m_dv = 1'b0;
            if (push && pop) begin
                if (mq.size() == 0) begin
                    m_dout = din;
                end else begin
                    m_dout = mq[mq.size()-1];
                    mq[mq.size()-1] = din;
                end
                m_dv = 1'b1;
            end else if (pop) begin
                if (mq.size() == 0) ue = 1'b1;
                else begin
                    m_dout = mq.pop_back();
                    m_dv   = 1'b1;
                end
            end else begin
                if (tos) begin
                    if (mq.size() == 0) ue = 1'b1;
                    else begin
                        m_dout = mq[mq.size()-1];
                        m_dv   = 1'b1;
                    end
                end
                if (push) begin
                    if (mq.size() == DEPTH) oe = 1'b1;
                    else mq.push_back(din);
                end
            end
`ifdef STACK_ERR_EN
            if (oe) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
            if (ue) m_unf = 1'b1;
            else if (err_clr) m_unf = 1'b0;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge the DUT must agree with the model
    always @(negedge clk) begin
        check("mdl_count", int'(count), mq.size());
        check("mdl_empty", int'(empty), int'(mq.size() == 0));
        check("mdl_full", int'(full), int'(mq.size() == DEPTH));
        check("mdl_dout", int'(dout), int'(m_dout));
        check("mdl_dv", int'(dout_valid), int'(m_dv));
`ifdef STACK_ERR_EN
        check("mdl_ovf", int'(ovf), int'(m_ovf));
        check("mdl_unf", int'(unf), int'(m_unf));
`endif
    end

    // Apply one cycle of request lines, then return them to idle just after the edge
    task automatic step(input bit pu, input bit po, input bit to, input logic [WIDTH-1:0] d,
                        input bit clr = 1'b0);
        push    = pu;
        pop     = po;
        tos     = to;
        din     = d;
        err_clr = clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        tos     = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_dv", int'(dout_valid), 0);

        // Fill, then overflow
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        step(1, 0, 0, 8'h44);
        check("fill_count", int'(count), 4);
        check("fill_full", int'(full), 1);
        step(1, 0, 0, 8'h55);
        check("ovf_count", int'(count), 4);
`ifdef STACK_ERR_EN
        check("ovf_flag", int'(ovf), 1);
`endif

        // Drain in reverse order
        step(0, 1, 0, 8'h00);
        check("pop1", int'(dout), 'h44);
        check("pop1_dv", int'(dout_valid), 1);
        step(0, 1, 0, 8'h00);
        check("pop2", int'(dout), 'h33);
        step(0, 1, 0, 8'h00);
        check("pop3", int'(dout), 'h22);
        step(0, 1, 0, 8'h00);
        check("pop4", int'(dout), 'h11);
        check("pop4_dv", int'(dout_valid), 1);
        check("drain_empty", int'(empty), 1);
        step(0, 1, 0, 8'h00);
        check("unf_dout_hold", int'(dout), 'h11);
        check("unf_dv", int'(dout_valid), 0);
        check("unf_count", int'(count), 0);
`ifdef STACK_ERR_EN
        check("unf_flag", int'(unf), 1);
        step(0, 0, 0, 8'h00, 1'b1);
        check("clr_ovf", int'(ovf), 0);
        check("clr_unf", int'(unf), 0);
`endif

        // tos and replace
        step(1, 0, 0, 8'hA0);
        step(0, 0, 1, 8'h00);
        check("tos1", int'(dout), 'hA0);
        check("tos1_count", int'(count), 1);
        step(0, 0, 1, 8'h00);
        check("tos2", int'(dout), 'hA0);
        check("tos2_dv", int'(dout_valid), 1);
        step(1, 1, 0, 8'hB0);
        check("repl_dout", int'(dout), 'hA0);
        check("repl_count", int'(count), 1);
        step(0, 1, 0, 8'h00);
        check("repl_pop", int'(dout), 'hB0);

        // Bypass on empty
        step(1, 1, 0, 8'h5A);
        check("byp_dout", int'(dout), 'h5A);
        check("byp_dv", int'(dout_valid), 1);
        check("byp_count", int'(count), 0);
`ifdef STACK_ERR_EN
        check("byp_unf", int'(unf), 0);
`endif

        // Replace while full
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 8'(i));
        step(1, 1, 0, 8'h99);
        check("frepl_dout", int'(dout), 'h04);
        check("frepl_count", int'(count), 4);
`ifdef STACK_ERR_EN
        check("frepl_ovf", int'(ovf), 0);
`endif
        step(0, 1, 0, 8'h00);
        check("frepl_pop", int'(dout), 'h99);

        // tos with push returns the pre-push top; tos with pop behaves as pop
        step(1, 0, 1, 8'h77);
        check("tospush_dout", int'(dout), 'h03);
        check("tospush_count", int'(count), 4);
        step(0, 1, 1, 8'h00);
        check("tospop_dout", int'(dout), 'h77);
        check("tospop_count", int'(count), 3);

        // Asynchronous reset mid-sequence with count=3 and dout_valid high
        #2 rst = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_dv", int'(dout_valid), 0);
        check("arst_empty", int'(empty), 1);
        @(posedge clk);
        #1 rst = 1'b1;

        // tos+push on empty: push occurs, no read
        step(1, 0, 1, 8'h12);
        check("tosempty_count", int'(count), 1);
        check("tosempty_dv", int'(dout_valid), 0);
`ifdef STACK_ERR_EN
        check("tosempty_unf", int'(unf), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h20);
        step(1, 0, 0, 8'h21, 1'b1);
        check("clr_vs_ovf", int'(ovf), 1);
        step(0, 0, 0, 8'h00, 1'b1);
        check("clr_after", int'(ovf), 0);
`endif

        step(0, 0, 0, 8'h00);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
